debounce_pulse: RTL and testbench

Input-conditioning stage directly upstream of the bounded counter: synchronises a raw, possibly bouncing 1-bit event line and qualifies it with a debounce filter. Each accepted rising edge produces exactly one single-cycle increment pulse, which drives the counter's `in` port. The block also exports the filtered level and a saturating count of rejected glitches. The block is also a BMC target: its safety properties are embedded and gated by a macro.

---
 rtl/debounce_pulse.sv | 202 ++++++++++++++++++++
 tb/tb_debounce_pulse.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// debounce_pulse: input conditioning for an event line feeding a bounded counter.
// A bouncing, asynchronous 1-bit line is synchronised, qualified by a debounce
// FSM and turned into one single-cycle increment strobe per accepted rising edge.
// The filtered level and a saturating count of aborted qualifications are exported.
//
// Optional build macro: DEBOUNCE_PULSE_FORMAL_EN
//   Defined   -> embedded safety assertions, history registers and the
//                first-cycle reset assumption are compiled in for BMC.
//   Undefined -> plain functional block, bit-identical behaviour.
module debounce_pulse #(
  parameter int unsigned STABLE = 4,  // consecutive samples to accept a change (1..255)
  parameter int unsigned GW     = 8   // glitch counter width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          raw,
  output logic          pulse,
  output logic          level,
  output logic [GW-1:0] glitches
);

  // FSM encoding
  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  // Last qualification count before a change is accepted.
  localparam logic [7:0]    LP_LAST  = 8'(STABLE - 1);
  // With a single required sample the qualifying states are bypassed entirely.
  localparam logic          LP_ONE   = (STABLE == 1) ? 1'b1 : 1'b0;
  localparam logic [GW-1:0] LP_G_ONE = GW'(1);
  localparam logic [GW-1:0] LP_G_MAX = '1;

  // Synchroniser stages
  logic r_s0;
  logic r_s1;

  // FSM state and qualification counter
  logic [1:0] r_state;
  logic [7:0] r_cnt;

  // Registered outputs
  logic          r_pulse;
  logic          r_level;
  logic [GW-1:0] r_glitches;

  // Next-state values
  logic [1:0] w_state_next;
  logic [7:0] w_cnt_next;
  logic       w_glitch_inc;
  logic       w_pulse_next;
  logic       w_level_next;

  // Two-flop synchroniser: the FSM only ever looks at r_s1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= raw;
      r_s1 <= r_s0;
    end
  end

  // Debounce FSM next-state and counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_glitch_inc = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (r_s1) begin
          if (LP_ONE) begin
            w_state_next = ST_HIGH;
          end else begin
            w_state_next = ST_RISE;
            w_cnt_next   = 8'd1;
          end
        end
      end
      ST_RISE: begin
        if (!r_s1) begin
          // Line fell back before qualifying: count it as a glitch.
          w_state_next = ST_LOW;
          w_cnt_next   = 8'd0;
          w_glitch_inc = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next   = r_cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (!r_s1) begin
          if (LP_ONE) begin
            w_state_next = ST_LOW;
          end else begin
            w_state_next = ST_FALL;
            w_cnt_next   = 8'd1;
          end
        end
      end
      ST_FALL: begin
        if (r_s1) begin
          // Aborted fall: return to HIGH without a new strobe.
          w_state_next = ST_HIGH;
          w_cnt_next   = 8'd0;
          w_glitch_inc = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_state_next = ST_LOW;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_LOW;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Strobe only on entry to HIGH from the low side; level follows the new state.
  always_comb begin
    w_pulse_next = (w_state_next == ST_HIGH) &&
                   ((r_state == ST_LOW) || (r_state == ST_RISE));
    w_level_next = (w_state_next == ST_HIGH) || (w_state_next == ST_FALL);
  end

  // State, counter and output registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= 8'd0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      r_level <= w_level_next;
    end
  end

  // Saturating glitch counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitches <= '0;
    end else if (w_glitch_inc && (r_glitches != LP_G_MAX)) begin
      r_glitches <= r_glitches + LP_G_ONE;
    end
  end

  assign pulse    = r_pulse;
  assign level    = r_level;
  assign glitches = r_glitches;

`ifdef DEBOUNCE_PULSE_FORMAL_EN
  logic r_past_pulse;
  logic r_past_level;
  logic r_init = 1'b1;

  // One-cycle history of the outputs for the edge-related properties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_past_pulse <= 1'b0;
      r_past_level <= 1'b0;
    end else begin
      r_past_pulse <= r_pulse;
      r_past_level <= r_level;
    end
  end

  always_ff @(posedge clk) begin
    r_init <= 1'b0;
  end

  // Safety properties checked on every active, non-reset edge.
  always @(posedge clk) begin
    if (!rst) begin
      assert (32'(r_cnt) < STABLE);
      assert ((r_state == ST_LOW) || (r_state == ST_RISE) ||
              (r_state == ST_HIGH) || (r_state == ST_FALL));
      assert (!r_pulse || r_level);
      assert (!(r_pulse && r_past_pulse));
      assert (!r_pulse || !r_past_level);
    end
  end

  // The design starts from reset in the very first cycle.
  always @* begin
    if (r_init) begin
      assume (rst);
    end
  end
`else
  // No checking logic in the functional build.
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse: scoreboard bench for debounce_pulse.
// Three instances: A (STABLE=4, GW=8), B (STABLE=4, GW=2), C (STABLE=1, GW=8).
// Stimulus pushes the expected edge number of each pulse; monitors pop on pulse.
module tb_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic       raw_a, raw_b, raw_c;
  logic       pulse_a, pulse_b, pulse_c;
  logic       level_a, level_b, level_c;
  logic [7:0] glitches_a;
  logic [1:0] glitches_b;
  logic [7:0] glitches_c;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Expected posedge index at which each pulse is registered.
  int q_a[$];
  int q_b[$];
  int q_c[$];

  int exp_sat[5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  debounce_pulse #(.STABLE(4), .GW(8)) u_a (
    .clk(clk), .rst(rst_a), .raw(raw_a),
    .pulse(pulse_a), .level(level_a), .glitches(glitches_a)
  );

  debounce_pulse #(.STABLE(4), .GW(2)) u_b (
    .clk(clk), .rst(rst_b), .raw(raw_b),
    .pulse(pulse_b), .level(level_b), .glitches(glitches_b)
  );

  debounce_pulse #(.STABLE(1), .GW(8)) u_c (
    .clk(clk), .rst(rst_c), .raw(raw_c),
    .pulse(pulse_c), .level(level_c), .glitches(glitches_c)
  );

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (edge %0d)", name, got, want, edge_n);
    end else begin
      $display("ok   %s got=%0d (edge %0d)", name, got, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor A: each pulse must match the head of its queue and coincide with level.
  always @(negedge clk) begin : mon_a
    int e;
    if (pulse_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_pulse", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_pulse_edge", edge_n, e);
        chk("a_pulse_level", int'(level_a), 1);
      end
    end
  end

  // Monitor B: this instance must never pulse.
  always @(negedge clk) begin : mon_b
    int e;
    if (pulse_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_pulse", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_pulse_edge", edge_n, e);
      end
    end
  end

  // Monitor C: STABLE=1 pulses.
  always @(negedge clk) begin : mon_c
    int e;
    if (pulse_c === 1'b1) begin
      if (q_c.size() == 0) begin
        chk("c_unexpected_pulse", 1, 0);
      end else begin
        e = q_c.pop_front();
        chk("c_pulse_edge", edge_n, e);
        chk("c_pulse_level", int'(level_c), 1);
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    raw_a = 1'b0; raw_b = 1'b0; raw_c = 1'b0;
    tick(2);

    // Reset state of all instances.
    chk("rst_a_pulse", int'(pulse_a), 0);
    chk("rst_a_level", int'(level_a), 0);
    chk("rst_a_glitches", int'(glitches_a), 0);
    chk("rst_b_pulse", int'(pulse_b), 0);
    chk("rst_b_level", int'(level_b), 0);
    chk("rst_b_glitches", int'(glitches_b), 0);
    chk("rst_c_pulse", int'(pulse_c), 0);
    chk("rst_c_level", int'(level_c), 0);
    chk("rst_c_glitches", int'(glitches_c), 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Quiet line for 20 cycles.
    tick(20);
    chk("idle_a_level", int'(level_a), 0);
    chk("idle_a_glitches", int'(glitches_a), 0);

    // Clean rise: first sample at edge_n+1, pulse after edge (edge_n+1)+1+4.
    raw_a = 1'b1;
    q_a.push_back(edge_n + 6);
    tick(12);
    chk("rise_a_level", int'(level_a), 1);
    chk("rise_a_glitches", int'(glitches_a), 0);

    // Clean fall: level still high after 5 edges, low after the 6th.
    raw_a = 1'b0;
    tick(5);
    chk("fall_a_level_before", int'(level_a), 1);
    tick(1);
    chk("fall_a_level_after", int'(level_a), 0);
    tick(4);

    // Bounce: high 2, low 1, high 10 -> one glitch, pulse timed from final rise.
    raw_a = 1'b1;
    tick(2);
    raw_a = 1'b0;
    tick(1);
    raw_a = 1'b1;
    q_a.push_back(edge_n + 6);
    tick(10);
    chk("bounce_a_glitches", int'(glitches_a), 1);
    chk("bounce_a_level", int'(level_a), 1);
    raw_a = 1'b0;
    tick(8);
    chk("bounce_a_fall_level", int'(level_a), 0);

    // Saturation on the 2-bit counter: 5 short bursts -> 1,2,3,3,3.
    for (int k = 0; k < 5; k++) begin
      raw_b = 1'b1;
      tick(2);
      raw_b = 1'b0;
      tick(6);
      chk("sat_b_glitches", int'(glitches_b), exp_sat[k]);
    end
    chk("sat_b_level", int'(level_b), 0);

    // STABLE=1: toggle every 2 cycles, pulse after edge (edge_n+1)+1+1.
    for (int k = 0; k < 4; k++) begin
      raw_c = 1'b1;
      q_c.push_back(edge_n + 3);
      tick(2);
      raw_c = 1'b0;
      tick(2);
    end
    tick(4);
    chk("s1_c_glitches", int'(glitches_c), 0);
    chk("s1_c_level", int'(level_c), 0);

    // Reset two cycles into RISE with raw held high across release.
    raw_a = 1'b1;
    tick(4);
    rst_a = 1'b1;
    tick(2);
    chk("midrise_a_glitches_cleared", int'(glitches_a), 0);
    chk("midrise_a_level", int'(level_a), 0);
    chk("midrise_a_pulse", int'(pulse_a), 0);
    rst_a = 1'b0;
    q_a.push_back(edge_n + 6);
    tick(10);
    chk("postrst_a_level", int'(level_a), 1);
    chk("postrst_a_glitches", int'(glitches_a), 0);

    // Drain: every expected pulse must have been seen.
    tick(10);
    chk("q_a_left", q_a.size(), 0);
    chk("q_b_left", q_b.size(), 0);
    chk("q_c_left", q_c.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
